// File: rtl/apb_multi_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_multi_slave_bridge
// Brief    : APB3 requester bridge driving NUM_SLV slaves from a valid/ready
//            command port, with decode-error and wait-state timeout handling.
// Revision : 1.0
// ============================================================================
module apb_multi_slave_bridge #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int NUM_SLV = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DERR   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [SEL_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_wcnt;
  logic [CNT_W-1:0]    w_wcnt;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic                w_accept;
  logic [SEL_W-1:0]    w_idx;
  logic                w_idx_ok;
  logic                w_sel_ready;
  logic                w_sel_err;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic [NUM_SLV-1:0]  w_psel;
  logic                w_rsp_valid;
  logic                w_rsp_err;
  logic [DATA_W-1:0]   w_rsp_rdata;

  assign w_idx    = cmd_addr[ADDR_W-1 -: SEL_W];
  assign w_idx_ok = ({1'b0, w_idx} < (SEL_W + 1)'(NUM_SLV));
  assign w_accept = cmd_valid & cmd_ready;

  // Only the addressed slave's handshake is observed; the rest are ignored.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    w_psel      = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_idx == SEL_W'(i)) begin
        w_sel_ready = PREADY[i];
        w_sel_err   = PSLVERR[i];
        w_sel_rdata = PRDATA[i*DATA_W +: DATA_W];
        w_psel[i]   = (r_state == S_SETUP) || (r_state == S_ACCESS);
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wcnt      = r_wcnt;
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_idx_ok ? S_SETUP : S_DERR;
          w_wcnt = '0;
        end
      end
      S_SETUP: begin
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_sel_ready) begin
          w_next      = S_IDLE;
          w_rsp_valid = 1'b1;
          w_rsp_err   = w_sel_err;
          w_rsp_rdata = (!r_pwrite && !w_sel_err) ? w_sel_rdata : '0;
        end else begin
          w_wcnt = r_wcnt + 1'b1;
          // Abort once this wait cycle brings the count up to TIMEOUT.
          if (r_wcnt == CNT_W'(TIMEOUT - 1)) begin
            w_next      = S_IDLE;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
          end
        end
      end
      S_DERR: begin
        w_next      = S_IDLE;
        w_rsp_valid = 1'b1;
        w_rsp_err   = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_idx       <= '0;
      r_wcnt      <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_wcnt      <= w_wcnt;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
      if (w_accept) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_idx    <= w_idx;
        if (cmd_write) begin
          r_pwdata <= cmd_wdata;
        end
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE) & ~PRESET;
  assign PSEL      = w_psel;
  assign PENABLE   = (r_state == S_ACCESS);
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_multi_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_multi_slave_bridge
// Brief    : Scoreboard bench for the APB bridge (2-slave and 3-slave builds).
// Revision : 1.0
// ============================================================================
module tb_apb_multi_slave_bridge;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default 2-slave build
  logic        a_valid, a_ready, a_wr;
  logic [8:0]  a_addr;
  logic [7:0]  a_wd;
  logic        a_rsp_valid, a_rsp_err;
  logic [7:0]  a_rsp_rdata;
  logic [1:0]  a_psel;
  logic        a_penable, a_pwrite;
  logic [8:0]  a_paddr;
  logic [7:0]  a_pwdata;
  logic [15:0] a_prdata;
  logic [1:0]  a_pready, a_pslverr;

  // Instance B: 3-slave build, so index 3 is undecodable
  logic        b_valid, b_ready, b_wr;
  logic [8:0]  b_addr;
  logic [7:0]  b_wd;
  logic        b_rsp_valid, b_rsp_err;
  logic [7:0]  b_rsp_rdata;
  logic [2:0]  b_psel;
  logic        b_penable, b_pwrite;
  logic [8:0]  b_paddr;
  logic [7:0]  b_pwdata;

  apb_multi_slave_bridge dut_a (
    .PCLK(clk), .PRESET(rst),
    .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_write(a_wr),
    .cmd_addr(a_addr), .cmd_wdata(a_wd),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite),
    .PADDR(a_paddr), .PWDATA(a_pwdata),
    .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr)
  );

  apb_multi_slave_bridge #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(16)) dut_b (
    .PCLK(clk), .PRESET(rst),
    .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_write(b_wr),
    .cmd_addr(b_addr), .cmd_wdata(b_wd),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite),
    .PADDR(b_paddr), .PWDATA(b_pwdata),
    .PRDATA(24'h77_66_55), .PREADY(3'b111), .PSLVERR(3'b000)
  );

  // Slave models for A: configurable wait states, error and read data.
  // Unselected slaves present not-ready/error to expose wrong-index use.
  int         wait_cfg [2];
  logic       err_cfg  [2];
  logic [7:0] rd_cfg   [2];
  int         scnt     [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_slv
    assign a_pready[gi]  = (a_psel[gi] & a_penable) ? (scnt[gi] >= wait_cfg[gi]) : 1'b0;
    assign a_pslverr[gi] = (a_psel[gi] & a_penable) ? err_cfg[gi] : 1'b1;
    assign a_prdata[gi*8 +: 8] = rd_cfg[gi];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (a_psel[i] && a_penable && !a_pready[i]) scnt[i] <= scnt[i] + 1;
      else if (!a_penable) scnt[i] <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard queues and expected APB bus contents
  exp_t       qa[$];
  exp_t       qb[$];
  exp_t       ea, eb;
  logic [1:0] a_exp_sel;
  logic [8:0] a_exp_addr;
  logic       a_exp_wr;
  logic [7:0] a_exp_wd;
  logic [2:0] b_exp_sel;
  logic       a_prev_act;

  always @(negedge clk) begin
    if (rst) begin
      a_prev_act <= 1'b0;
    end else begin
      if (a_penable && a_psel == 2'b00) begin
        checks++; errors++;
        $display("FAIL a_penable_without_psel: got penable=1 psel=0 expected psel!=0");
      end
      if (a_psel != 2'b00) begin
        chk("a_psel", a_psel, a_exp_sel);
        chk("a_paddr", a_paddr, a_exp_addr);
        chk("a_pwrite", a_pwrite, a_exp_wr);
        chk("a_pwdata", a_pwdata, a_exp_wd);
        chk("a_penable_phase", a_penable, a_prev_act);
      end
      a_prev_act <= (a_psel != 2'b00);
      if (a_rsp_valid) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          ea = qa.pop_front();
          chk("a_rsp_cycle", cyc, ea.cyc);
          chk("a_rsp_err", a_rsp_err, ea.err);
          chk("a_rsp_rdata", a_rsp_rdata, ea.rd);
          chk("a_bus_idle_on_rsp", {a_psel, a_penable}, 0);
          chk("a_ready_on_rsp", a_ready, 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b_psel != 3'b000) chk("b_psel", b_psel, b_exp_sel);
      if (b_rsp_valid) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          eb = qb.pop_front();
          chk("b_rsp_cycle", cyc, eb.cyc);
          chk("b_rsp_err", b_rsp_err, eb.err);
          chk("b_rsp_rdata", b_rsp_rdata, eb.rd);
        end
      end
    end
  end

  // Issue one command; lat = edges from accept to the rsp_valid cycle.
  task automatic send(input bit b, input bit wr, input logic [8:0] addr, input logic [7:0] wd,
                      input int lat, input logic [7:0] erd, input logic eerr, input bit hold,
                      output int acc);
    int   n;
    exp_t e;
    logic [1:0] idx;
    if (!b) begin a_wr = wr; a_addr = addr; a_wd = wd; a_valid = 1'b1; end
    else    begin b_wr = wr; b_addr = addr; b_wd = wd; b_valid = 1'b1; end
    n = 0;
    while (!(b ? b_ready : a_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got cmd_ready=0 for 200 cycles expected 1");
      a_valid = 1'b0; b_valid = 1'b0; acc = -1;
      return;
    end
    acc   = cyc + 1;
    e.cyc = acc + lat;
    e.rd  = erd;
    e.err = eerr;
    if (!b) begin
      qa.push_back(e);
      a_exp_sel  = 2'b01 << addr[8];
      a_exp_addr = addr;
      a_exp_wr   = wr;
      if (wr) a_exp_wd = wd;
    end else begin
      qb.push_back(e);
      idx = addr[8:7];
      b_exp_sel = (idx < 2'd3) ? (3'b001 << idx) : 3'b000;
    end
    @(posedge clk);
    #1;
    if (!hold) begin a_valid = 1'b0; b_valid = 1'b0; end
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0", qa.size(), qb.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc1, acc2;
    rst = 1'b1;
    a_valid = 0; a_wr = 0; a_addr = '0; a_wd = '0;
    b_valid = 0; b_wr = 0; b_addr = '0; b_wd = '0;
    wait_cfg[0] = 0; wait_cfg[1] = 0;
    err_cfg[0]  = 0; err_cfg[1]  = 0;
    rd_cfg[0]   = 8'h00; rd_cfg[1] = 8'h00;
    a_exp_sel = '0; a_exp_addr = '0; a_exp_wr = 0; a_exp_wd = '0; b_exp_sel = '0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready", a_ready, 0);
    chk("rst_b_cmd_ready", b_ready, 0);
    chk("rst_psel", a_psel, 0);
    chk("rst_penable", a_penable, 0);
    chk("rst_pwrite", a_pwrite, 0);
    chk("rst_paddr", a_paddr, 0);
    chk("rst_pwdata", a_pwdata, 0);
    chk("rst_rsp", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", a_ready, 1);

    // Zero-wait write to slave 0
    send(0, 1, 9'h005, 8'hA5, 2, 8'h00, 0, 0, acc1);
    // Read from slave 1 with 3 wait states; PWDATA must keep 0xA5
    wait_cfg[1] = 3; rd_cfg[1] = 8'h3C;
    send(0, 0, 9'h105, 8'hFF, 5, 8'h3C, 0, 0, acc1);

    // Decode error on the 3-slave build, then a valid read of slave 2
    send(1, 0, 9'h1C0, 8'h00, 1, 8'h00, 1, 0, acc1);
    send(1, 0, 9'h100, 8'h00, 2, 8'h77, 0, 0, acc1);
    drain();

    // Timeout: slave 0 never ready, 16 ACCESS cycles then abort
    wait_cfg[0] = 1000;
    send(0, 1, 9'h010, 8'hC3, 17, 8'h00, 1, 0, acc1);
    drain();
    wait_cfg[0] = 0;

    // Slave error masks read data; back-to-back accept on the rsp cycle
    err_cfg[0] = 1; rd_cfg[0] = 8'h99; wait_cfg[1] = 0; rd_cfg[1] = 8'h5A;
    send(0, 0, 9'h020, 8'h00, 2, 8'h00, 1, 1, acc1);
    send(0, 0, 9'h1FF, 8'h00, 2, 8'h5A, 0, 0, acc2);
    chk("b2b_accept_gap", acc2, acc1 + 3);
    send(0, 1, 9'h030, 8'h6B, 2, 8'h00, 1, 0, acc1);
    drain();
    err_cfg[0] = 0;
    // Write returns zero data even though the slave drives PRDATA
    wait_cfg[1] = 1;
    send(0, 1, 9'h180, 8'h3E, 3, 8'h00, 0, 0, acc1);
    drain();

    // Reset during ACCESS
    wait_cfg[0] = 1000;
    @(negedge clk);
    a_exp_sel = 2'b01; a_exp_addr = 9'h033; a_exp_wr = 1'b0;
    a_wr = 0; a_addr = 9'h033; a_valid = 1'b1;
    chk("rst_test_ready", a_ready, 1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    chk("access_before_reset", {a_psel, a_penable}, 3'b011);
    rst = 1'b1;
    #1;
    chk("reset_drops_psel", a_psel, 0);
    chk("reset_drops_penable", a_penable, 0);
    chk("reset_cmd_ready", a_ready, 0);
    a_exp_wd = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_cfg[0] = 0;
    @(negedge clk);
    chk("ready_after_mid_reset", a_ready, 1);
    chk("paddr_after_mid_reset", a_paddr, 0);
    repeat (3) @(negedge clk);

    // Recovery transfer
    send(0, 1, 9'h0AA, 8'h11, 2, 8'h00, 0, 0, acc1);
    drain();
    chk("pending_a", qa.size(), 0);
    chk("pending_b", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
